// File: rtl/inst_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buffer
//
// Instruction prefetch buffer between instruction memory and the IF-ID
// register. It keeps at most one memory request outstanding, stores the
// returned words with their PCs in a DEPTH-entry FIFO, and presents the FIFO
// head to the consumer. A decode-stage redirect flushes the FIFO and restarts
// fetching at redirect_pc. A response that is still in flight when the
// redirect arrives is discarded.
//
// Optional feature (macro PREFETCH_BYPASS_EN): while the FIFO is empty, a
// memory response is forwarded straight to if_inst/if_pc in the cycle it
// arrives. If the consumer takes it in that cycle, it is not stored.
//
// Handshakes:
//   imem_req/imem_ack : imem_req stays high, with imem_addr stable, from the
//                       issue cycle until the cycle that carries imem_ack.
//                       imem_ack is a single-cycle pulse and comes no earlier
//                       than the cycle after the issue cycle.
//   if_valid/if_ready : the head moves on in a cycle where if_valid and
//                       if_ready are both high and redirect is low.
//
// Parameters:
//   DEPTH     number of FIFO entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   redirect          branch taken in decode: flush and refetch
//   redirect_pc       new fetch address, sampled with redirect
//   imem_req          memory request
//   imem_addr         byte address of the request
//   imem_ack          memory response valid (one per request)
//   imem_rdata        instruction word, valid with imem_ack
//   if_valid          if_inst/if_pc hold a valid instruction
//   if_ready          consumer accepts this cycle
//   if_inst           instruction at the FIFO head (0 when empty)
//   if_pc             PC of if_inst (0 when empty)
//   dbg_state         current fetch FSM state (debug only)
// ---------------------------------------------------------------------------
module inst_prefetch_buffer #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [7:0]  if_pc,
    output logic [1:0]  dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // no request outstanding
        S_WAIT = 2'd1,  // request outstanding, response will be kept
        S_DROP = 2'd2   // request outstanding, response will be discarded
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       fetch_pc_q, fetch_pc_d;
    logic [7:0]       req_addr_q, req_addr_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      inst_mem_q [DEPTH];
    logic [7:0]       pc_mem_q   [DEPTH];

    logic req_raw;
    logic push_req;
    logic push;
    logic pop;
    logic flush;
    logic fifo_empty;
    logic bypass_take;

    // Fetch FSM: next state, request, and push/flush decisions.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        req_raw    = 1'b0;
        push_req   = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                end else if (count_q < DEPTH_C) begin
                    // Issue only when a slot is free for the response.
                    req_raw    = 1'b1;
                    req_addr_d = fetch_pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                req_raw = 1'b1;
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    push_req   = 1'b1;
                    fetch_pc_d = fetch_pc_q + 8'd4;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                req_raw = 1'b1;
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Consumer-side outputs. In IDLE the address comes from fetch_pc. Once a
    // request is out, it is held in req_addr so that a redirect cannot move it.
    always_comb begin
        fifo_empty  = (count_q == '0);
        if_valid    = !fifo_empty;
        if_inst     = fifo_empty ? 32'h0000_0000 : inst_mem_q[rd_ptr_q];
        if_pc       = fifo_empty ? 8'h00 : pc_mem_q[rd_ptr_q];
        bypass_take = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        if (fifo_empty && (state_q == S_WAIT) && imem_ack && !redirect) begin
            if_valid    = 1'b1;
            if_inst     = imem_rdata;
            if_pc       = req_addr_q;
            bypass_take = if_ready;
        end
`endif
    end

    assign imem_addr = (state_q == S_IDLE) ? fetch_pc_q : req_addr_q;
    assign imem_req  = req_raw && !rst;
    assign pop       = !fifo_empty && if_ready && !redirect;
    assign push      = push_req && !bypass_take;
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                // DEPTH is a power of two, so the pointers wrap by overflow.
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
module tb_inst_prefetch_buffer;

  localparam int         DEPTH    = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [7:0]  if_pc;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .dbg_state(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the instructions the buffer should hold, oldest first:
  // {pc[7:0], inst[31:0]}.
  logic [39:0] exp_q[$];
  logic [7:0]  m_fetch_pc;
  bit          m_out;       // a request is in flight
  logic [7:0]  m_out_addr;
  bit          m_out_drop;  // in-flight response must be thrown away

  // memory responder
  bit          mem_busy;
  int          mem_wait;
  int          mem_lat;
  int          lat_lo = 1;
  int          lat_hi = 1;

  // logs of observed activity for directed checks
  logic [7:0]  pop_log[$];
  logic [7:0]  issue_log[$];
  int          n_acks;
  bit          last_ack;
  logic        last_req;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_seq(input string tag, input logic [7:0] log[$], input int idx,
                           input logic [7:0] exp);
    logic [8:0] got;
    got = (idx < log.size()) ? {1'b0, log[idx]} : 9'h1FF;
    check_eq(tag, {31'b0, got}, {32'b0, exp});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    m_out      = 1'b0;
    m_out_drop = 1'b0;
    m_out_addr = 8'h00;
    mem_busy   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},  {39'b0, imem_req}, 40'd0);
    check_eq({tag, "_val"},  {39'b0, if_valid}, 40'd0);
    check_eq({tag, "_addr"}, {32'b0, imem_addr}, {32'b0, RESET_PC});
    check_eq({tag, "_inst"}, {8'b0, if_inst}, 40'd0);
    check_eq({tag, "_pc"},   {32'b0, if_pc}, 40'd0);
  endtask

  // Assert reset for a few cycles. Release happens in the next step.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
    #1;
    check_reset_outputs("rst_now");
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
  endtask

  // One clock cycle. red_mode: 0 no redirect, 1 redirect, 2 redirect only
  // if the memory acks this cycle. stray forces an ack with none pending.
  task automatic step(input int red_mode, input logic [7:0] rpc, input logic rdy,
                      input bit stray);
    logic        ack, red, byp, issue;
    logic [31:0] rdata;
    logic        e_req, e_valid;
    logic [7:0]  e_addr, e_pc;
    logic [31:0] e_inst;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    if (mem_busy) begin
      mem_wait++;
      if (mem_wait >= mem_lat) ack = 1'b1;
    end
    if (stray) ack = 1'b1;
    rdata = $urandom;
    red = (red_mode == 1) || (red_mode == 2 && ack);
    redirect = red; redirect_pc = rpc; if_ready = rdy;
    imem_ack = ack; imem_rdata = rdata;

    // expected outputs for this cycle
    e_req  = m_out || (!red && exp_q.size() < DEPTH);
    e_addr = m_out ? m_out_addr : m_fetch_pc;
    byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp = (exp_q.size() == 0) && m_out && !m_out_drop && ack && !red;
`endif
    e_valid = (exp_q.size() != 0) || byp;
    e_pc    = byp ? m_out_addr : (exp_q.size() != 0 ? exp_q[0][39:32] : 8'h00);
    e_inst  = byp ? rdata      : (exp_q.size() != 0 ? exp_q[0][31:0]  : 32'h0);

    #1;
    check_eq("imem_req",  {39'b0, imem_req}, {39'b0, e_req});
    check_eq("imem_addr", {32'b0, imem_addr}, {32'b0, e_addr});
    check_eq("if_valid",  {39'b0, if_valid}, {39'b0, e_valid});
    check_eq("if_pc",     {32'b0, if_pc}, {32'b0, e_pc});
    check_eq("if_inst",   {8'b0, if_inst}, {8'b0, e_inst});

    last_req = imem_req;
    last_ack = ack && m_out;
    if (ack && m_out) n_acks++;
    if (if_valid && rdy && !red) pop_log.push_back(if_pc);

    // advance the model across the coming edge
    issue = !m_out && !red && (exp_q.size() < DEPTH);
    if (issue) issue_log.push_back(imem_addr);
    if (red) begin
      exp_q.delete();
      m_fetch_pc = rpc;
      if (m_out) begin
        if (ack) m_out = 1'b0;
        else     m_out_drop = 1'b1;
      end
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (m_out && ack) begin
        if (!m_out_drop) begin
          if (!(byp && rdy)) exp_q.push_back({m_out_addr, rdata});
          m_fetch_pc = m_fetch_pc + 8'd4;
        end
        m_out = 1'b0;
      end else if (issue) begin
        m_out      = 1'b1;
        m_out_addr = m_fetch_pc;
        m_out_drop = 1'b0;
      end
    end
    if (exp_q.size() > DEPTH) check_eq("overflow", 40'(exp_q.size()), 40'(DEPTH));

    // memory responder bookkeeping
    if (ack) mem_busy = 1'b0;
    if (m_out && !mem_busy) begin
      mem_busy = 1'b1;
      mem_wait = 0;
      mem_lat  = $urandom_range(lat_hi, lat_lo);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit hit;
    model_reset();
    n_acks = 0;

    // reset state
    #1;
    check_reset_outputs("por");

    // in-order fetch, latency 1, always ready
    do_reset();
    lat_lo = 1; lat_hi = 1;
    pop_log.delete(); issue_log.delete();
    repeat (8) step(0, 8'h00, 1'b1, 1'b0);
    check_seq("t1_issue0", issue_log, 0, 8'h00);
    check_seq("t1_issue1", issue_log, 1, 8'h04);
    check_seq("t1_issue2", issue_log, 2, 8'h08);
    check_seq("t1_pop0", pop_log, 0, 8'h00);
    check_seq("t1_pop1", pop_log, 1, 8'h04);
    check_seq("t1_pop2", pop_log, 2, 8'h08);

    // stall: buffer fills to DEPTH, requests stop, resume after one pop
    do_reset();
    n_acks = 0;
    repeat (20) step(0, 8'h00, 1'b0, 1'b0);
    check_eq("t2_acks", 40'(n_acks), 40'(DEPTH));
    check_eq("t2_req_off", {39'b0, last_req}, 40'd0);
    issue_log.delete();
    repeat (3) step(0, 8'h00, 1'b1, 1'b0);
    check_seq("t2_resume", issue_log, 0, 8'h10);

    // redirect while waiting on 0C, ack two cycles later is dropped
    do_reset();
    lat_lo = 3; lat_hi = 3;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (m_out && m_out_addr == 8'h0C && mem_busy && mem_wait == 0) hit = 1'b1;
      else step(0, 8'h00, 1'b1, 1'b0);
    end
    check_eq("t3_reach", {39'b0, hit}, 40'd1);
    step(1, 8'h40, 1'b1, 1'b0);
    pop_log.delete(); issue_log.delete();
    repeat (15) step(0, 8'h00, 1'b1, 1'b0);
    check_seq("t3_issue", issue_log, 0, 8'h40);
    check_seq("t3_pop", pop_log, 0, 8'h40);

    // redirect in the same cycle as ack
    lat_lo = 2; lat_hi = 2;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(2, 8'h80, 1'b1, 1'b0);
      if (last_ack && redirect) hit = 1'b1;
    end
    check_eq("t4_reach", {39'b0, hit}, 40'd1);
    pop_log.delete(); issue_log.delete();
    step(0, 8'h00, 1'b1, 1'b0);
    check_eq("t4_no_pop", 40'(pop_log.size()), 40'd0);
    repeat (3) step(0, 8'h00, 1'b1, 1'b0);
    check_seq("t4_issue", issue_log, 0, 8'h80);

    // PC wrap FC -> 00
    lat_lo = 1; lat_hi = 1;
    step(1, 8'hF8, 1'b1, 1'b0);
    pop_log.delete(); issue_log.delete();
    repeat (16) step(0, 8'h00, 1'b1, 1'b0);
    check_seq("t5_issue1", issue_log, 1, 8'hFC);
    check_seq("t5_issue2", issue_log, 2, 8'h00);
    check_seq("t5_pop0", pop_log, 0, 8'hF8);
    check_seq("t5_pop1", pop_log, 1, 8'hFC);
    check_seq("t5_pop2", pop_log, 2, 8'h00);

    // reset while a request is outstanding; stray ack right after release
    lat_lo = 3; lat_hi = 3;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (m_out) hit = 1'b1;
      else step(0, 8'h00, 1'b1, 1'b0);
    end
    check_eq("t6_reach", {39'b0, hit}, 40'd1);
    do_reset();
    issue_log.delete();
    step(0, 8'h00, 1'b1, 1'b1);
    repeat (3) step(0, 8'h00, 1'b1, 1'b0);
    check_seq("t6_issue", issue_log, 0, RESET_PC);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      lat_lo = 1; lat_hi = 3;
      if ($urandom_range(0, 299) == 0) do_reset();
      step(($urandom_range(0, 19) == 0) ? 1 : 0, 8'($urandom),
           ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of instruction FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 8'h00, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port redirect, input, 1 bit: decode-stage branch taken; flush the buffer and refetch.
REQ-006 SHALL have port redirect_pc, input, 8 bits: new fetch address, sampled when redirect=1.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-008 SHALL have port imem_addr, output, 8 bits: byte address of the request.
REQ-009 SHALL have port imem_ack, input, 1 bit: memory response valid, one cycle per request.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction word, valid with imem_ack.
REQ-011 SHALL have port if_valid, output, 1 bit: if_inst and if_pc hold a valid instruction.
REQ-012 SHALL have port if_ready, input, 1 bit: consumer (IF-ID register) accepts this cycle; low means stall.
REQ-013 SHALL have port if_inst, output, 32 bits: instruction at the FIFO head.
REQ-014 SHALL have port if_pc, output, 8 bits: PC of if_inst.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE (no outstanding request), WAIT (request outstanding), DROP (outstanding request to be discarded).
REQ-016 SHALL assert imem_req in IDLE when (count + 0) < DEPTH and redirect=0, then enter WAIT next cycle.
REQ-017 SHALL hold imem_req=1 and imem_addr stable throughout WAIT/DROP until imem_ack; at most one outstanding request.
REQ-018 SHALL, in WAIT on imem_ack, push {fetch_pc, imem_rdata}, advance fetch_pc by 4 (8-bit wrap, 8'hFC -> 8'h00), and return to IDLE.
REQ-019 SHALL, on redirect with no outstanding request, empty the FIFO, load fetch_pc <= redirect_pc, and stay in IDLE.
REQ-020 SHALL, on redirect in WAIT without same-cycle ack, empty the FIFO, load redirect_pc, and enter DROP.
REQ-021 SHALL, on redirect in the same cycle as imem_ack, discard the ack data, load redirect_pc, and go to IDLE.
REQ-022 SHALL, in DROP on imem_ack, discard the data and go to IDLE; a further redirect in DROP only reloads fetch_pc.
REQ-023 SHALL pop the head when if_valid and if_ready are both 1 and redirect=0; redirect overrides push and pop.
REQ-024 SHALL permit simultaneous push and pop; count unchanged, pointers wrap modulo DEPTH.
REQ-025 SHALL never overflow: requests are only issued when a slot is free for the response.
REQ-026 SHALL drive if_valid=0, if_inst=32'h0000_0000 (bubble), and if_pc=8'h00 when the FIFO is empty.
REQ-027 SHALL preserve fetch order; if_pc of consecutive pops differs by 4 except across a redirect.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, imem_req=0, and if_valid=0.
REQ-029 SHALL drive imem_addr=RESET_PC, if_inst=0, and if_pc=0 during reset.
REQ-030 SHALL, when reset is asserted mid-request, abandon the request; an imem_ack in the first cycle after reset is ignored.

Configuration
REQ-031 SHALL use macro PREFETCH_BYPASS_EN to control an empty-FIFO bypass.
REQ-032 SHALL, when PREFETCH_BYPASS_EN is defined and the FIFO is empty, drive imem_ack data onto if_inst/if_pc with if_valid=1 in the same cycle, unless a redirect is present.
REQ-033 SHALL, when bypassed data is taken with if_ready=1, not write it into the FIFO.
REQ-034 SHALL, when PREFETCH_BYPASS_EN is not defined, give a minimum ack-to-if_valid latency of 1 cycle.

Verification
REQ-035 SHALL cover: release reset with ack latency 1 and if_ready=1 -> imem_addr sequence 00,04,08; if_pc pops 00,04,08 in order.
REQ-036 SHALL cover: if_ready=0 and DEPTH=4 -> exactly 4 acks accepted, then imem_req=0; count stays 4; raise if_ready -> resumes after first pop.
REQ-037 SHALL cover: redirect=1, redirect_pc=8'h40 while WAIT at addr 0C, ack 2 cycles later -> ack data dropped; next imem_addr=40; first if_pc=40.
REQ-038 SHALL cover: redirect in the same cycle as imem_ack -> no push; FIFO empty; next request addr = redirect_pc.
REQ-039 SHALL cover: fetch_pc=FC, ack -> next imem_addr=00; popped if_pc sequence FC,00.
REQ-040 SHALL cover: assert rst during WAIT -> imem_req=0, if_valid=0 immediately; after release first imem_addr=RESET_PC.
